// File: rtl/wishbone_target_classic_if.sv
// Wishbone classic bus bundle between one initiator and one register-file target.
// The err_o wire only exists when WB_TARGET_ERR_EN is defined.
interface wishbone_target_classic_if #(
    parameter int DAT_WIDTH = 8,
    parameter int ADR_WIDTH = 4
);
    logic                 cyc_i;
    logic                 stb_i;
    logic                 we_i;
    logic [ADR_WIDTH-1:0] adr_i;
    logic [DAT_WIDTH-1:0] dat_i;
    logic [DAT_WIDTH-1:0] dat_o;
    logic                 ack_o;
`ifdef WB_TARGET_ERR_EN
    logic                 err_o;

    modport master (output cyc_i, stb_i, we_i, adr_i, dat_i,
                    input  dat_o, ack_o, err_o);
    modport slave  (input  cyc_i, stb_i, we_i, adr_i, dat_i,
                    output dat_o, ack_o, err_o);
`else
    modport master (output cyc_i, stb_i, we_i, adr_i, dat_i,
                    input  dat_o, ack_o);
    modport slave  (input  cyc_i, stb_i, we_i, adr_i, dat_i,
                    output dat_o, ack_o);
`endif
endinterface

// File: rtl/wishbone_target_classic.sv
// Wishbone classic register-file target with programmable wait states.
// Define WB_TARGET_ERR_EN to terminate out-of-range accesses with err_o instead of ack_o.
module wishbone_target_classic #(
    parameter int DAT_WIDTH   = 8,
    parameter int ADR_WIDTH   = 4,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    wishbone_target_classic_if.slave  bus
);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
    localparam logic [ADR_WIDTH:0] DEPTH_L = (ADR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 req, accept, enter_ack;
    logic                 we_q, we_sel;
    logic [ADR_WIDTH-1:0] adr_q, adr_sel;
    logic [DAT_WIDTH-1:0] dat_q;
    logic [DAT_WIDTH-1:0] rdat_q;
    logic                 ack_q;
    logic [DAT_WIDTH-1:0] regs [DEPTH];

    function automatic logic in_range(input logic [ADR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    assign req = bus.cyc_i && bus.stb_i;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                // Initiator gave up: drop the transfer without touching the registers.
                if (!req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = ACK;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With zero wait states ACK is entered on the accepting edge, before the latches update.
    assign enter_ack = (state_nxt == ACK);
    assign adr_sel   = accept ? bus.adr_i : adr_q;
    assign we_sel    = accept ? bus.we_i  : we_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
        end else if (accept) begin
            we_q  <= bus.we_i;
            adr_q <= bus.adr_i;
            dat_q <= bus.dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdat_q <= '0;
        end else if (enter_ack && !we_sel) begin
            rdat_q <= in_range(adr_sel) ? regs[adr_sel] : '0;
        end
    end

    // Writes commit only on the edge leaving ACK, so a reset during ACK cancels them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (state == ACK && we_q && in_range(adr_q)) begin
            regs[adr_q] <= dat_q;
        end
    end

`ifdef WB_TARGET_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= enter_ack &&  in_range(adr_sel);
            err_q <= enter_ack && !in_range(adr_sel);
        end
    end

    assign bus.err_o = err_q;
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ack_q <= 1'b0;
        else         ack_q <= enter_ack;
    end
`endif

    assign bus.ack_o = ack_q;
    assign bus.dat_o = rdat_q;
endmodule

// File: tb/tb_wishbone_target_classic.sv
// Randomized bench driving three target instances (0, 3 and 2 wait states; DEPTH 16, 16, 10)
// against a transaction-level register model.
module tb_wishbone_target_classic;
    localparam int ND = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cyc_s [ND];
    logic       stb_s [ND];
    logic       we_s  [ND];
    logic [3:0] adr_s [ND];
    logic [7:0] dat_s [ND];
    logic       ack_m [ND];
    logic       err_m [ND];
    logic [7:0] rd_m  [ND];

    logic [7:0] mem_m [ND][16];
    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
    endfunction

    function automatic int dp_of(input int d);
        return (d == 2) ? 10 : 16;
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        wishbone_target_classic_if #(.DAT_WIDTH(8), .ADR_WIDTH(4)) bus ();
        assign bus.cyc_i = cyc_s[g];
        assign bus.stb_i = stb_s[g];
        assign bus.we_i  = we_s[g];
        assign bus.adr_i = adr_s[g];
        assign bus.dat_i = dat_s[g];
        assign ack_m[g]  = bus.ack_o;
        assign rd_m[g]   = bus.dat_o;
`ifdef WB_TARGET_ERR_EN
        assign err_m[g]  = bus.err_o;
`else
        assign err_m[g]  = 1'b0;
`endif
        wishbone_target_classic #(
            .DAT_WIDTH(8), .ADR_WIDTH(4),
            .DEPTH((g == 2) ? 10 : 16),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
        ) u_dut (
            .clk_i (clk),
            .rst_ni(rst_n),
            .bus   (bus)
        );
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < ND; d++)
            for (int a = 0; a < 16; a++) mem_m[d][a] = 8'h00;
    endtask

    // One transfer on target d. b2b: stb was held high from the previous ack.
    // keep: leave stb high afterwards for a back-to-back successor.
    // abort_n > 0: drop the strobe after that many edges while still waiting.
    task automatic xfer(input int d, input bit we, input logic [3:0] a, input logic [7:0] wd,
                        input int abort_n, input bit b2b, input bit keep);
        int         n;
        int         hits;
        int         exp_n;
        bit         got;
        bit         oor;
        logic [7:0] exp_rd;
        oor    = (a >= dp_of(d));
        exp_rd = oor ? 8'h00 : mem_m[d][a];
        @(negedge clk);
        cyc_s[d] = 1'b1; stb_s[d] = 1'b1;
        we_s[d]  = we;   adr_s[d] = a; dat_s[d] = wd;
        if (abort_n > 0) begin
            hits = 0;
            repeat (abort_n) begin
                @(posedge clk); #1;
                if (ack_m[d] || err_m[d]) hits++;
            end
            @(negedge clk);
            cyc_s[d] = 1'b0; stb_s[d] = 1'b0;
            repeat (ws_of(d) + 3) begin
                @(posedge clk); #1;
                if (ack_m[d] || err_m[d]) hits++;
            end
            check_val("abort_noack", hits, 0);
            return;
        end
        exp_n = 1 + ws_of(d) + (b2b ? 1 : 0);
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ack_m[d] || err_m[d]) got = 1'b1;
        end
        check_val("latency", n, exp_n);
        if (got) begin
`ifdef WB_TARGET_ERR_EN
            check_val("ack_term", ack_m[d], !oor);
            check_val("err_term", err_m[d], oor);
`else
            check_val("ack_term", ack_m[d], 1'b1);
`endif
            if (!we) check_val("rdata", rd_m[d], exp_rd);
            if (we && !oor) mem_m[d][a] = wd;
        end
        if (!keep) begin
            @(negedge clk);
            cyc_s[d] = 1'b0; stb_s[d] = 1'b0;
            @(posedge clk); #1;
            check_val("term_one_cycle", ack_m[d] || err_m[d], 1'b0);
            if (!we && got) check_val("rdata_hold", rd_m[d], exp_rd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         d, len, ab;
        bit         we;
        logic [3:0] a;
        logic [7:0] v;

        rst_n = 1'b0;
        for (int i = 0; i < ND; i++) begin
            cyc_s[i] = 1'b0; stb_s[i] = 1'b0; we_s[i] = 1'b0;
            adr_s[i] = 4'h0; dat_s[i] = 8'h00;
        end
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < ND; i++) begin
            check_val("reset_ack", ack_m[i], 1'b0);
            check_val("reset_dat", rd_m[i], 8'h00);
`ifdef WB_TARGET_ERR_EN
            check_val("reset_err", err_m[i], 1'b0);
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back, zero wait states.
        xfer(0, 1'b1, 4'd3, 8'hA5, 0, 1'b0, 1'b0);
        xfer(0, 1'b0, 4'd3, 8'h00, 0, 1'b0, 1'b0);
        // Three wait states.
        xfer(1, 1'b0, 4'd5, 8'h00, 0, 1'b0, 1'b0);
        // Back-to-back writes, then readback.
        xfer(0, 1'b1, 4'd0, 8'h11, 0, 1'b0, 1'b1);
        xfer(0, 1'b1, 4'd1, 8'h22, 0, 1'b1, 1'b0);
        xfer(0, 1'b0, 4'd0, 8'h00, 0, 1'b0, 1'b1);
        xfer(0, 1'b0, 4'd1, 8'h00, 0, 1'b1, 1'b0);
        // Read of the address written in the immediately preceding transfer.
        xfer(1, 1'b1, 4'd6, 8'h3C, 0, 1'b0, 1'b1);
        xfer(1, 1'b0, 4'd6, 8'h00, 0, 1'b1, 1'b0);
        // Aborted writes during wait states.
        xfer(2, 1'b1, 4'd2, 8'h7E, 1, 1'b0, 1'b0);
        xfer(2, 1'b1, 4'd2, 8'h7E, 2, 1'b0, 1'b0);
        xfer(2, 1'b0, 4'd2, 8'h00, 0, 1'b0, 1'b0);
        // Out-of-range access on the DEPTH=10 target.
        xfer(2, 1'b1, 4'd12, 8'h99, 0, 1'b0, 1'b0);
        xfer(2, 1'b0, 4'd12, 8'h00, 0, 1'b0, 1'b0);
        xfer(2, 1'b1, 4'd9, 8'h5A, 0, 1'b0, 1'b0);
        xfer(2, 1'b0, 4'd9, 8'h00, 0, 1'b0, 1'b0);

        // Reset pulse while a write sits in ACK.
        @(negedge clk);
        cyc_s[0] = 1'b1; stb_s[0] = 1'b1; we_s[0] = 1'b1; adr_s[0] = 4'd4; dat_s[0] = 8'h5C;
        @(posedge clk); #1;
        check_val("rst_pre_ack", ack_m[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("rst_ack_drop", ack_m[0], 1'b0);
        for (int i = 0; i < ND; i++) check_val("rst_dat_clear", rd_m[i], 8'h00);
        cyc_s[0] = 1'b0; stb_s[0] = 1'b0;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        xfer(0, 1'b0, 4'd4, 8'h00, 0, 1'b0, 1'b0);
        xfer(1, 1'b0, 4'd6, 8'h00, 0, 1'b0, 1'b0);

        // Random bursts.
        for (int it = 0; it < 80; it++) begin
            d   = $urandom_range(0, ND - 1);
            len = $urandom_range(1, 3);
            for (int k = 0; k < len; k++) begin
                we = 1'($urandom_range(0, 1));
                a  = 4'($urandom_range(0, 15));
                v  = 8'($urandom);
                ab = 0;
                if (len == 1 && ws_of(d) > 0 && $urandom_range(0, 4) == 0)
                    ab = $urandom_range(1, ws_of(d));
                xfer(d, we, a, v, ab, k > 0, k < len - 1);
            end
        end

        // Final sweep: every register of every target must match the model.
        for (int dd = 0; dd < ND; dd++)
            for (int aa = 0; aa < 16; aa++)
                xfer(dd, 1'b0, 4'(aa), 8'h00, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
